// File: rtl/fp_conv_sched_pkg.sv
// fp_conv_sched_pkg: shared types for the converter scheduler.
// Holds default sizing, the op encoding and the in-flight tag bundle.
package fp_conv_sched_pkg;

   localparam int EXP_W  = 5;
   localparam int MANT_W = 10;
   localparam int WORD_W = 1 + EXP_W + MANT_W;
   localparam int NREQ_N = 4;
   localparam int LAT_N  = 4;
   localparam int ID_W   = $clog2(NREQ_N);

   typedef enum logic {
      OP_I2F = 1'b0,
      OP_F2I = 1'b1
   } op_e;

   typedef struct packed {
      logic            valid;
      op_e             op;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fp_conv_sched_if.sv
// fp_conv_sched_if: requester-side bundle of the converter scheduler.
// Ports: req_valid/req_op/req_data (to slave), req_ready/rsp_valid/rsp_data (from slave).
interface fp_conv_sched_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_op;
   logic [NREQ-1:0][WIDTH-1:0] req_data;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0]            rsp_valid;
   logic [WIDTH-1:0]           rsp_data;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/fp_conv_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with internal last-grant pointer.
// Ports: clock, clock_sreset, enable, req in; grant (one-hot), grant_id out.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clock,
   input  logic            clock_sreset,
   input  logic            enable,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_id
);

   logic [IW-1:0] ptr;
   logic          found;
   int            c;

   // Search begins one past the last winner so every requester gets a turn.
   always_comb begin
      grant    = '0;
      grant_id = ptr;
      found    = 1'b0;
      c        = 0;
      if (enable && !clock_sreset) begin
         for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!found && req[IW'(c)]) begin
               found           = 1'b1;
               grant[IW'(c)]   = 1'b1;
               grant_id        = IW'(c);
            end
         end
      end
   end

   // Reset to the last index so requester 0 wins first.
   always_ff @(posedge clock) begin
      if (clock_sreset) ptr <= IW'(NREQ - 1);
      else if (found)   ptr <= grant_id;
   end

endmodule

// File: rtl/fp_conv_sched.sv
// fp_conv_sched: shares one i2f and one f2i converter among NREQ requesters.
// Ports: clock, clock_sreset, enable; bus (requests/responses); i2f_*/f2i_* converter
// issue and return; busy (tags in flight); error (sticky tag/result mismatch).
module fp_conv_sched
   import fp_conv_sched_pkg::*;
#(
   parameter int EXP     = 5,
   parameter int MANT    = 10,
   parameter int WIDTH   = 1 + EXP + MANT,
   parameter int NREQ    = 4,
   parameter int LATENCY = 4
) (
   input  logic              clock,
   input  logic              clock_sreset,
   input  logic              enable,
   fp_conv_sched_if.slave    bus,
   output logic              i2f_valid,
   output logic [MANT:0]     i2f_dataa,
   input  logic              i2f_result_valid,
   input  logic [WIDTH-1:0]  i2f_result,
   output logic              f2i_valid,
   output logic [WIDTH-1:0]  f2i_dataa,
   input  logic              f2i_result_valid,
   input  logic [MANT-1:0]   f2i_result,
   output logic              busy,
   output logic              error
);

   logic [NREQ-1:0] grant;
   logic [ID_W-1:0] gid;
   logic            issue;
   op_e             gop;
   tag_t            tags [LATENCY];
   tag_t            last;
   logic            i2f_hit;
   logic            f2i_hit;
   logic            bad;
   logic            good;
   logic            err_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clock        (clock),
      .clock_sreset (clock_sreset),
      .enable       (enable),
      .req          (bus.req_valid),
      .grant        (grant),
      .grant_id     (gid)
   );

   assign issue         = |grant;
   assign gop           = op_e'(bus.req_op[gid]);
   assign bus.req_ready = grant;

   always_comb begin
      i2f_valid = issue && (gop == OP_I2F);
      f2i_valid = issue && (gop == OP_F2I);
      i2f_dataa = '0;
      f2i_dataa = '0;
      if (i2f_valid) i2f_dataa = bus.req_data[gid][MANT:0];
      if (f2i_valid) f2i_dataa = bus.req_data[gid];
   end

   // Tag pipe mirrors converter latency; the last stage names the owner
   // of whatever result the converters present this cycle.
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         for (int j = 0; j < LATENCY; j++) tags[j] <= '0;
         err_q <= 1'b0;
      end else begin
         tags[0] <= tag_t'{valid: issue, op: gop, id: gid};
         for (int j = 1; j < LATENCY; j++) tags[j] <= tags[j-1];
         if (bad) err_q <= 1'b1;
      end
   end

   assign last = tags[LATENCY-1];

   // Any disagreement between tag and result strobes suppresses the response.
   always_comb begin
      i2f_hit = last.valid && (last.op == OP_I2F);
      f2i_hit = last.valid && (last.op == OP_F2I);
      bad     = (i2f_hit != i2f_result_valid) ||
                (f2i_hit != f2i_result_valid);
      good    = last.valid && !bad && !clock_sreset;
      bus.rsp_valid = '0;
      bus.rsp_data  = '0;
      if (good) begin
         bus.rsp_valid = NREQ'(1) << last.id;
         if (i2f_hit) bus.rsp_data = i2f_result;
         else         bus.rsp_data = WIDTH'(f2i_result);
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int j = 0; j < LATENCY; j++) busy = busy | tags[j].valid;
   end

   assign error = err_q;

endmodule

// File: doc/fp_conv_sched.md
FP_CONV_SCHED -- requirements
Module: fp_conv_sched

Interface
REQ-001 Parameters SHALL be: EXP, 5, exponent width; MANT, 10, mantissa width; WIDTH, 1+EXP+MANT, float word width; NREQ, 4, requester count; LATENCY, 4, converter pipeline depth in cycles.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 clock_sreset  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  when low, no new grants; in-flight ops complete.
REQ-005 req_valid  in  NREQ  per-requester request.
REQ-006 req_op  in  NREQ  per-requester op: 0 = int-to-float, 1 = float-to-int.
REQ-007 req_data  in  NREQ x WIDTH  operand: bits [MANT:0] for i2f, full word for f2i.
REQ-008 req_ready  out  NREQ  one-hot grant; combinational from req_valid, enable, rr pointer.
REQ-009 i2f_valid / i2f_dataa  out  1 / MANT+1  issue to int-to-float converter.
REQ-010 i2f_result_valid / i2f_result  in  1 / WIDTH  converter return.
REQ-011 f2i_valid / f2i_dataa  out  1 / WIDTH  issue to float-to-int converter.
REQ-012 f2i_result_valid / f2i_result  in  1 / MANT  converter return.
REQ-013 rsp_valid  out  NREQ  one-hot response strobe, single cycle, no backpressure.
REQ-014 rsp_data  out  WIDTH  i2f result, or f2i result zero-extended to WIDTH.
REQ-015 busy  out  1  high while any tag stage valid.
REQ-016 error  out  1  sticky tag/result mismatch flag.

Function
REQ-017 At most one issue per cycle across both converters; issue occurs when req_valid[i] and req_ready[i].
REQ-018 Arbitration SHALL be round-robin: search starts at pointer+1 mod NREQ; pointer loads granted index only on a grant.
REQ-019 No grant when enable low or no req_valid; pointer holds.
REQ-020 Issue SHALL drive i2f_valid or f2i_valid (per req_op) combinationally in the grant cycle with req_data routed; the other valid stays low.
REQ-021 Tag pipeline of LATENCY stages SHALL carry {valid, op, id}; stage 0 loads on issue, shifts every cycle.
REQ-022 When last tag stage valid and the matching converter result_valid is high, rsp_valid[id] SHALL pulse with rsp_data from that converter, LATENCY cycles after issue.
REQ-023 Last tag stage valid without matching result_valid, or any result_valid without a valid tag of that op: error sets, no rsp_valid that cycle.
REQ-024 error SHALL stay set until clock_sreset.
REQ-025 Back-to-back issues every cycle SHALL yield back-to-back responses in issue order.
REQ-026 Same-cycle issue and response SHALL both occur.
REQ-027 rsp_data SHALL be zero when rsp_valid is all-zero.

Reset
REQ-028 On clock_sreset: tag stages invalid, pointer = NREQ-1 (requester 0 first), error = 0, rsp_valid = 0, busy = 0.
REQ-029 req_ready, i2f_valid, f2i_valid SHALL be 0 during the reset cycle.
REQ-030 Reset mid-operation discards in-flight tags; converters share clock_sreset, so no stale results arrive.

Structure
REQ-031 Shared package SHALL hold the op encoding enum (OP_I2F, OP_F2I) and the tag struct {valid, op, id}.
REQ-032 Round-robin arbiter SHALL be one sub-module, rr_arbiter (NREQ-parameterised, one-hot grant, pointer register inside).
REQ-033 Converters are external; the bench instantiates fp_i2f and fp_f2i with LATENCY matching.

Verification
REQ-034 Single req0 i2f, data 123 -> rsp_valid=0001 after LATENCY cycles, rsp_data = 16'h57B0.
REQ-035 All four requesting continuously, alternating ops -> grants 0,1,2,3,0,... each response id matches grant order, no error.
REQ-036 i2f of 130 then f2i of the returned float -> final rsp_data = 130.
REQ-037 enable low with req_valid=1111 for 5 cycles -> req_ready=0000, in-flight responses still delivered, busy falls.
REQ-038 Force f2i_result_valid with no tag -> error=1, held until clock_sreset.
REQ-039 clock_sreset asserted 2 cycles after issue -> no rsp_valid, busy=0, next grant to requester 0.
